wb_timer_multi: RTL and testbench
=================================

# wb_timer_multi

Parametrised multi-channel Wishbone timer for the RV SoC peripheral bus: CHANNELS independent WIDTH-bit up-counters share one programmable prescaler. Each channel has a compare register, periodic or one-shot mode, and a match flag. Enabled match flags are ORed into a single level interrupt that drives the core's timer interrupt input. Classic single-beat Wishbone slave with a registered ack.

## Interface
- CHANNELS, 4, number of timer channels, 1..8
- WIDTH, 32, counter/compare width, 8..32; read data zero-extended to 32 bits
- PRESCALE_W, 16, prescaler width, 1..32
- wb_clk  in  1  clock; all logic rising-edge
- wb_rst_n  in  1  reset, asynchronous assert, active-low
- wb_adr  in  8  byte address; bits [7:2] decoded, [1:0] ignored
- wb_dat  in  32  write data
- wb_sel  in  4  ignored; every write is a full 32-bit write
- wb_we  in  1  write enable
- wb_cyc  in  1  bus cycle
- wb_stb  in  1  strobe
- wb_rdt  out  32  read data, registered, valid with wb_ack
- wb_ack  out  1  single-cycle acknowledge
- irq  out  1  |(IRQ_STAT & IRQ_EN), level

## Operation
- Register map (byte offsets):
  - 0x00 PRESC: reload value, PRESCALE_W bits.
  - 0x04 IRQ_STAT: bit c is channel c's match flag; write-1-to-clear.
  - 0x08 IRQ_EN: bit c enables channel c onto irq.
  - Channel c at 0x10+16*c:
    - +0x0 CTRL: bit0 EN, bit1 ONESHOT, bit2 USE_PRESC.
    - +0x4 COUNT.
    - +0x8 CMP.
- Unmapped offsets, including channels >= CHANNELS: read 0, writes ignored, still acked.
- Prescaler:
  - Counter pcnt counts 0..PRESC, then returns to 0.
  - tick is high in the cycle pcnt==PRESC, so one tick every PRESC+1 clocks.
  - PRESC=0 gives a tick every cycle.
  - Writing PRESC clears pcnt.
- Channel step condition: EN & (USE_PRESC ? tick : 1).
- On a step:
  - If COUNT==CMP: COUNT<=0, set IRQ_STAT[c]; if ONESHOT, clear EN.
  - Otherwise COUNT<=COUNT+1, modulo 2^WIDTH. If CMP is never reached, COUNT wraps from all-ones to 0 and sets no flag.
- Precedence:
  - A bus write to any register of channel c suppresses that channel's step in the same cycle. The written value lands and no flag is set.
  - For IRQ_STAT, a hardware set wins over a same-cycle W1C of the same bit.
- Reset values: all registers 0, pcnt 0, wb_ack 0, wb_rdt 0, irq 0.

## Timing
- Ack: wb_ack goes high one cycle after a cycle with wb_cyc & wb_stb & !wb_ack, for exactly one cycle. Back-to-back requests are therefore acked every second cycle.
- Writes take effect at the ack edge; the new value is readable from the next access.
- Reads: wb_rdt is captured at the ack edge and reflects register state in the request cycle.
- Count latency:
  - With USE_PRESC=0, COUNT increments on every edge after the EN write has landed.
  - A match at COUNT==CMP sets IRQ_STAT on that edge; irq is high the following cycle, combinational from registers.
  - Periodic period is (CMP+1) steps.
- Reset is asynchronous. Asserting it mid-transaction drops wb_ack at once, and the transaction is lost. Deassertion is synchronised externally.
- Dropping wb_stb before the ack is not supported; the ack is still issued.

## Test plan
- Reset/default: hold wb_rst_n=0 then release, read all offsets -> all 0; irq=0; read 0xF0 -> 0 with ack.
- Periodic, no prescale: CMP0=4, IRQ_EN=1, CTRL0=0x1 -> IRQ_STAT[0] sets every 5 cycles and COUNT0 cycles 0..4. Write IRQ_STAT=1 -> irq drops next cycle and re-asserts 5 steps later.
- One-shot with prescale: PRESC=3, CMP1=2, CTRL1=0x7 -> flag sets after 12 clocks. CTRL1 then reads 0x6 and COUNT1 stays 0.
- Wrap, WIDTH=8: CMP=0xFF-free setup with CMP0=0x10, COUNT0 written 0x11 -> counts to 0xFF, wraps to 0x00, reaches 0x10, then sets the flag.
- Collisions:
  - Write COUNT2=7 in the cycle the channel would match -> COUNT2 reads 7 and no flag is set.
  - W1C of a bit in the same cycle as its match -> the bit remains 1.
- Multi-channel: channels 0 and 3 enabled with different CMP and IRQ_EN=0x8 -> only channel 3 drives irq; both flags are visible in IRQ_STAT.

Source files
------------

// File: rtl/wb_timer_multi.sv
//------------------------------------------------------------------------------
// wb_timer_multi
//
// Multi-channel Wishbone timer. CHANNELS independent WIDTH-bit up-counters
// share one programmable prescaler. Each channel has a compare register,
// periodic or one-shot mode and a match flag. Enabled match flags are ORed
// into a single level interrupt.
//
// Register map (byte offsets, adr[7:2] decoded):
//   0x00            PRESC     prescaler reload value (PRESCALE_W bits)
//   0x04            IRQ_STAT  per-channel match flags, write-1-to-clear
//   0x08            IRQ_EN    per-channel interrupt enables
//   0x10 + 16*c     CTRL      bit0 EN, bit1 ONESHOT, bit2 USE_PRESC
//   0x14 + 16*c     COUNT
//   0x18 + 16*c     CMP
//   Anything else reads 0, ignores writes and is still acked.
//
// Ports:
//   wb_clk    in   clock, rising edge
//   wb_rst_n  in   asynchronous active-low reset
//   wb_adr    in   byte address [7:0]
//   wb_dat    in   write data [31:0]
//   wb_sel    in   byte selects, ignored (all writes are full-word)
//   wb_we     in   write enable
//   wb_cyc    in   bus cycle
//   wb_stb    in   strobe
//   wb_rdt    out  registered read data, valid with wb_ack
//   wb_ack    out  single-cycle registered acknowledge
//   irq       out  |(IRQ_STAT & IRQ_EN), level
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module wb_timer_multi #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [7:0]  wb_adr,
  input  logic [31:0] wb_dat,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic [31:0] wb_rdt,
  output logic        wb_ack,
  output logic        irq
);

  // Sub-register offsets inside a 16-byte channel block.
  typedef enum logic [1:0] {
    SUB_CTRL  = 2'd0,
    SUB_COUNT = 2'd1,
    SUB_CMP   = 2'd2,
    SUB_NONE  = 2'd3
  } ch_sub_e;

  // Word offsets of the global registers.
  localparam logic [5:0] W_PRESC    = 6'd0;
  localparam logic [5:0] W_IRQ_STAT = 6'd1;
  localparam logic [5:0] W_IRQ_EN   = 6'd2;

  //----------------------------------------------------------------------------
  // State
  //----------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] presc;
  logic [PRESCALE_W-1:0] pcnt;
  logic [CHANNELS-1:0]   irq_stat;
  logic [CHANNELS-1:0]   irq_en;
  logic [CHANNELS-1:0]   en;
  logic [CHANNELS-1:0]   oneshot;
  logic [CHANNELS-1:0]   use_presc;
  logic [WIDTH-1:0]      count [CHANNELS];
  logic [WIDTH-1:0]      cmp   [CHANNELS];

  //----------------------------------------------------------------------------
  // Bus decode
  //----------------------------------------------------------------------------
  logic       req;
  logic       wr;
  logic [5:0] word;
  logic [3:0] blk;
  ch_sub_e    sub;

  // A request is only taken while no ack is pending, which is what makes
  // back-to-back requests complete every second cycle.
  assign req  = wb_cyc & wb_stb & ~wb_ack;
  assign wr   = req & wb_we;
  assign word = wb_adr[7:2];
  assign blk  = wb_adr[7:4];
  assign sub  = ch_sub_e'(wb_adr[3:2]);

  // Byte selects and the byte lane bits carry no meaning for this block.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{wb_sel, wb_adr[1:0]};

  logic wr_presc;
  logic wr_stat;
  logic wr_irq_en;

  assign wr_presc  = wr && (word == W_PRESC);
  assign wr_stat   = wr && (word == W_IRQ_STAT);
  assign wr_irq_en = wr && (word == W_IRQ_EN);

  //----------------------------------------------------------------------------
  // Prescaler
  //----------------------------------------------------------------------------
  logic tick;
  assign tick = (pcnt == presc);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (wr_presc) begin
        presc <= wb_dat[PRESCALE_W-1:0];
        pcnt  <= '0;
      end else if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_W'(1);
      end
    end
  end

  //----------------------------------------------------------------------------
  // Per-channel step / match evaluation
  //----------------------------------------------------------------------------
  logic [CHANNELS-1:0] ch_hit;    // address falls in channel c's block
  logic [CHANNELS-1:0] wr_ch;     // bus write to one of channel c's registers
  logic [CHANNELS-1:0] step;
  logic [CHANNELS-1:0] set_mask;  // hardware flag sets this cycle

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional logic, so no path leaves it unassigned and no latch forms.
    ch_hit   = '0;
    wr_ch    = '0;
    step     = '0;
    set_mask = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_hit[c]   = (blk == 4'(c + 1));
      // A bus write to the channel owns it for the cycle: no step, no flag.
      wr_ch[c]    = wr && ch_hit[c] && (sub != SUB_NONE);
      step[c]     = en[c] && (use_presc[c] ? tick : 1'b1) && !wr_ch[c];
      set_mask[c] = step[c] && (count[c] == cmp[c]);
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      en        <= '0;
      oneshot   <= '0;
      use_presc <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        count[c] <= '0;
        cmp[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_ch[c] && (sub == SUB_CTRL)) begin
          {use_presc[c], oneshot[c], en[c]} <= wb_dat[2:0];
        end else if (set_mask[c] && oneshot[c]) begin
          en[c] <= 1'b0;
        end

        if (wr_ch[c] && (sub == SUB_COUNT)) begin
          count[c] <= wb_dat[WIDTH-1:0];
        end else if (step[c]) begin
          count[c] <= (count[c] == cmp[c]) ? '0 : count[c] + WIDTH'(1);
        end

        if (wr_ch[c] && (sub == SUB_CMP)) begin
          cmp[c] <= wb_dat[WIDTH-1:0];
        end
      end
    end
  end

  //----------------------------------------------------------------------------
  // Interrupt status / enable
  //----------------------------------------------------------------------------
  logic [CHANNELS-1:0] w1c_mask;
  assign w1c_mask = wr_stat ? wb_dat[CHANNELS-1:0] : '0;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      irq_stat <= '0;
      irq_en   <= '0;
    end else begin
      // Set is ORed in after the clear, so a same-cycle match survives a W1C.
      irq_stat <= (irq_stat & ~w1c_mask) | set_mask;
      if (wr_irq_en) begin
        irq_en <= wb_dat[CHANNELS-1:0];
      end
    end
  end

  assign irq = |(irq_stat & irq_en);

  //----------------------------------------------------------------------------
  // Read mux and registered response
  //----------------------------------------------------------------------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (word)
      W_PRESC:    rdata[PRESCALE_W-1:0] = presc;
      W_IRQ_STAT: rdata[CHANNELS-1:0]   = irq_stat;
      W_IRQ_EN:   rdata[CHANNELS-1:0]   = irq_en;
      default: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (ch_hit[c]) begin
            case (sub)
              SUB_CTRL:  rdata[2:0]       = {use_presc[c], oneshot[c], en[c]};
              SUB_COUNT: rdata[WIDTH-1:0] = count[c];
              SUB_CMP:   rdata[WIDTH-1:0] = cmp[c];
              default:   rdata            = '0;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_ack <= 1'b0;
      wb_rdt <= '0;
    end else begin
      wb_ack <= req;
      if (req) begin
        wb_rdt <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_wb_timer_multi.sv
//------------------------------------------------------------------------------
// tb_wb_timer_multi
//
// Directed testbench for wb_timer_multi. Two instances share the bus inputs:
// dut32 (WIDTH=32) and dut8 (WIDTH=8, used for the counter wrap case).
// Expected values are hand-derived from the edge at which the last
// programming write lands (called E0 in the comments below); bus accesses
// land every second edge when issued back to back.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wb_timer_multi;

  logic        wb_clk   = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [7:0]  wb_adr   = '0;
  logic [31:0] wb_dat   = '0;
  logic [3:0]  wb_sel   = 4'hF;
  logic        wb_we    = 1'b0;
  logic        wb_cyc   = 1'b0;
  logic        wb_stb   = 1'b0;

  logic [31:0] rdt32, rdt8;
  logic        ack32, ack8;
  logic        irq32, irq8;

  logic        use8 = 1'b0;   // select which instance a read returns
  int          n_vec = 0;
  int          n_err = 0;

  always #5 wb_clk = ~wb_clk;

  wb_timer_multi #(.CHANNELS(4), .WIDTH(32), .PRESCALE_W(16)) dut32 (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .wb_adr  (wb_adr),
    .wb_dat  (wb_dat),
    .wb_sel  (wb_sel),
    .wb_we   (wb_we),
    .wb_cyc  (wb_cyc),
    .wb_stb  (wb_stb),
    .wb_rdt  (rdt32),
    .wb_ack  (ack32),
    .irq     (irq32)
  );

  wb_timer_multi #(.CHANNELS(4), .WIDTH(8), .PRESCALE_W(16)) dut8 (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .wb_adr  (wb_adr),
    .wb_dat  (wb_dat),
    .wb_sel  (wb_sel),
    .wb_we   (wb_we),
    .wb_cyc  (wb_cyc),
    .wb_stb  (wb_stb),
    .wb_rdt  (rdt8),
    .wb_ack  (ack8),
    .irq     (irq8)
  );

  //----------------------------------------------------------------------------
  // Helpers
  //----------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One single-beat access: request at a negedge, wait (bounded) for the ack,
  // sample 1 ns after the acking edge, then drop the request.
  task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    logic got_ack;
    @(negedge wb_clk);
    wb_adr = a;
    wb_dat = d;
    wb_we  = w;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    got_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk);
      #1;
      if (ack32) begin
        got_ack = 1'b1;
        break;
      end
    end
    r      = use8 ? rdt8 : rdt32;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    if (!got_ack) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] unused_r;
    bus(1'b1, a, d, unused_r);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a,
                        input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'd0, r);
    check(tag, r, exp);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  // Number of edges until the selected irq is high, 0 if not within max.
  task automatic wait_irq(input logic sel8, input int max, output int k);
    k = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge wb_clk);
      #1;
      if (sel8 ? irq8 : irq32) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    use8     = 1'b0;
    repeat (2) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
  endtask

  //----------------------------------------------------------------------------
  // Stimulus
  //----------------------------------------------------------------------------
  initial begin
    int k;

    // ---- Reset / defaults ----------------------------------------------------
    do_reset();
    check("rst_ack", {31'd0, ack32}, 32'd0);
    check("rst_rdt", rdt32, 32'd0);
    check("rst_irq", {31'd0, irq32}, 32'd0);
    for (int a = 0; a <= 8'h4C; a += 4) begin
      rd_chk($sformatf("rst_rd_%02h", a), 8'(a), 32'd0);
    end
    rd_chk("rst_rd_f0", 8'hF0, 32'd0);

    // Width masking and unmapped writes.
    wr(8'h00, 32'hFFFF_FFFF);
    rd_chk("presc_width", 8'h00, 32'h0000_FFFF);
    wr(8'h00, 32'd0);
    wr(8'h08, 32'h0000_00FF);
    rd_chk("irq_en_width", 8'h08, 32'h0000_000F);
    wr(8'h0C, 32'hFFFF_FFFF);
    wr(8'h50, 32'h0000_0007);   // would be channel 4 CTRL; does not exist
    wr(8'h1C, 32'hFFFF_FFFF);   // unused slot inside channel 0
    rd_chk("unmapped_0c", 8'h0C, 32'd0);
    rd_chk("unmapped_50", 8'h50, 32'd0);
    rd_chk("no_alias_ctrl0", 8'h10, 32'd0);
    rd_chk("unmapped_1c", 8'h1C, 32'd0);

    // ---- Periodic, no prescale ----------------------------------------------
    do_reset();
    wr(8'h18, 32'd4);           // CMP0
    wr(8'h08, 32'd1);           // IRQ_EN
    wr(8'h10, 32'h1);           // CTRL0 EN, lands at E0
    // COUNT after E_k is k mod 5; first match at E5.
    wait_irq(1'b0, 20, k);
    check("periodic_first_irq", 32'(k), 32'd5);
    rd_chk("periodic_cnt_e6", 8'h14, 32'd0);   // value after E5
    rd_chk("periodic_cnt_e8", 8'h14, 32'd2);   // after E7
    rd_chk("periodic_cnt_e10", 8'h14, 32'd4);  // after E9
    rd_chk("periodic_cnt_e12", 8'h14, 32'd1);  // after E11
    wr(8'h04, 32'd1);                          // W1C lands at E14
    check("w1c_irq_low", {31'd0, irq32}, 32'd0);
    tick_n(1);                                 // E15 is the next match
    check("periodic_irq_again", {31'd0, irq32}, 32'd1);
    tick_n(4);
    wr(8'h04, 32'd1);                          // W1C lands at E20, a match edge
    rd_chk("w1c_vs_set", 8'h04, 32'd1);

    // ---- One-shot with prescale ---------------------------------------------
    do_reset();
    wr(8'h08, 32'd2);           // IRQ_EN ch1
    wr(8'h28, 32'd2);           // CMP1
    wr(8'h00, 32'd3);           // PRESC, lands at P, pcnt cleared
    wr(8'h20, 32'h7);           // CTRL1 EN|ONESHOT|USE_PRESC, E0 = P+2
    // Ticks at P+4, P+8, P+12; third step matches: E0+10 (12 clocks after P).
    wait_irq(1'b0, 20, k);
    check("oneshot_first_irq", 32'(k), 32'd10);
    rd_chk("oneshot_ctrl", 8'h20, 32'h6);
    rd_chk("oneshot_cnt", 8'h24, 32'd0);
    tick_n(10);
    rd_chk("oneshot_cnt_hold", 8'h24, 32'd0);
    rd_chk("oneshot_stat", 8'h04, 32'd2);

    // ---- Wrap, WIDTH=8 ------------------------------------------------------
    do_reset();
    wr(8'h08, 32'd1);
    wr(8'h18, 32'h10);          // CMP0
    wr(8'h14, 32'h11);          // COUNT0
    wr(8'h10, 32'h1);           // CTRL0 EN at E0
    // 8-bit: 0x11 -> 0xFF -> 0x00 -> 0x10 after E255, match at E256.
    wait_irq(1'b1, 300, k);
    check("wrap_first_irq", 32'(k), 32'd256);
    check("wide_no_irq", {31'd0, irq32}, 32'd0);
    rd_chk("wide_count", 8'h14, 32'h111);      // lands E257, after E256
    use8 = 1'b1;
    rd_chk("wrap_count", 8'h14, 32'h02);       // lands E259, after E258
    rd_chk("wrap_stat", 8'h04, 32'd1);
    use8 = 1'b0;

    // ---- Collision: COUNT write on the match edge ---------------------------
    do_reset();
    wr(8'h38, 32'd3);           // CMP2
    wr(8'h08, 32'd4);
    wr(8'h30, 32'h1);           // CTRL2 EN at E0; would match at E4
    tick_n(3);
    wr(8'h34, 32'd7);           // COUNT2 write lands at E4
    check("coll_irq", {31'd0, irq32}, 32'd0);
    rd_chk("coll_count", 8'h34, 32'd8);        // 7 at E4, +1 at E5
    rd_chk("coll_stat", 8'h04, 32'd0);

    // ---- Multi-channel ------------------------------------------------------
    do_reset();
    wr(8'h18, 32'd2);           // CMP0
    wr(8'h48, 32'd5);           // CMP3
    wr(8'h08, 32'h8);           // only channel 3 on irq
    wr(8'h10, 32'h1);           // CTRL0 EN at A
    wr(8'h40, 32'h1);           // CTRL3 EN at B = A+2; ch3 matches at B+6
    wait_irq(1'b0, 20, k);
    check("multi_first_irq", 32'(k), 32'd6);
    rd_chk("multi_stat", 8'h04, 32'h9);
    rd_chk("multi_irq_en", 8'h08, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
